// File: rtl/sprite_pkg.sv
// Shared sprite codes and sizes: tile size, facing/frame codes used by the
// ROM bank select, and the movement controller state encoding.
package sprite_pkg;

    // Tile size in screen pixels; must be a power of 2.
    localparam int unsigned SPRITE_LEN     = 32;
    localparam int unsigned SPRITE_LOG_LEN = $clog2(SPRITE_LEN);

    // Screen coordinate width, and the widened width used for bounds checks.
    localparam int unsigned POS_W = 10;
    localparam int unsigned CHK_W = 11;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        FRM_STAND  = 2'd0,
        FRM_WALK_A = 2'd1,
        FRM_WALK_B = 2'd2
    } frame_e;

    typedef enum logic [1:0] {
        MV_IDLE = 2'd0,
        MV_WALK = 2'd1,
        MV_BUMP = 2'd2
    } mv_state_e;

    // True when a full tile move stays inside [lo, hi]; toward_lo selects
    // the decreasing direction (up/left).
    function automatic logic move_legal(
        input logic [CHK_W-1:0] pos,
        input logic [CHK_W-1:0] lo,
        input logic [CHK_W-1:0] hi,
        input logic             toward_lo
    );
        logic [CHK_W-1:0] len;
        len = CHK_W'(SPRITE_LEN);
        if (toward_lo) begin
            return pos >= lo + len;
        end
        return pos + len <= hi;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Pixel-step divider for the sprite walk.
//   clk, rst : block clock, async active-low reset
//   clr      : force the divider to 0 (used outside WALK)
//   en       : count enable (WALK and not frozen)
//   tick_c   : high on the enabled cycle where the divider sits at STEP_DIV-1
module step_tick_gen #(
    parameter int unsigned STEP_DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned         DIV_W    = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick_c = en && (div_cnt == DIV_LAST);

    // Wraps at STEP_DIV-1 so the count never leaves 0..STEP_DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Tile-step movement controller for the player sprite.
// Arbitrates the debounced direction buttons (up > down > left > right),
// walks one tile per accepted request at one pixel per STEP_DIV clocks,
// rejects moves that would leave the play field, and drives the ROM bank
// select (facing + walk frame).
//   clk, rst                      : block clock, async active-low reset
//   req_up/down/left/right        : debounced level requests
//   freeze                        : hold all state while high
//   pos_r, pos_c                  : sprite top-left row / column
//   facing                        : dir_e code
//   frame                         : frame_e code
//   busy                          : high while walking
//   blocked                       : one-cycle pulse on a rejected request
module sprite_move_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned STEP_DIV = 32,
    parameter int unsigned INIT_R   = 300,
    parameter int unsigned INIT_C   = 300,
    parameter int unsigned MIN_R    = 0,
    parameter int unsigned MAX_R    = 448,
    parameter int unsigned MIN_C    = 0,
    parameter int unsigned MAX_C    = 608
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_up,
    input  logic             req_down,
    input  logic             req_left,
    input  logic             req_right,
    input  logic             freeze,
    output logic [POS_W-1:0] pos_r,
    output logic [POS_W-1:0] pos_c,
    output logic [1:0]       facing,
    output logic [1:0]       frame,
    output logic             busy,
    output logic             blocked
);

    localparam logic [CHK_W-1:0] MIN_R_W = CHK_W'(MIN_R);
    localparam logic [CHK_W-1:0] MAX_R_W = CHK_W'(MAX_R);
    localparam logic [CHK_W-1:0] MIN_C_W = CHK_W'(MIN_C);
    localparam logic [CHK_W-1:0] MAX_C_W = CHK_W'(MAX_C);

    localparam logic [SPRITE_LOG_LEN-1:0] PIX_LAST = SPRITE_LOG_LEN'(SPRITE_LEN - 1);
    localparam logic [SPRITE_LOG_LEN-1:0] PIX_HALF = SPRITE_LOG_LEN'(SPRITE_LEN / 2);

    mv_state_e                 state_q;
    mv_state_e                 state_d;
    logic [SPRITE_LOG_LEN-1:0] pix_cnt;
    logic [SPRITE_LOG_LEN-1:0] pix_d;
    logic [POS_W-1:0]          pos_r_d;
    logic [POS_W-1:0]          pos_c_d;
    dir_e                      facing_d;
    frame_e                    frame_d;
    logic                      busy_d;
    logic                      blocked_d;

    dir_e req_dir;
    logic req_any;
    logic req_legal;
    logic tick_c;
    logic walk_en;
    logic div_clr;

    assign req_any = req_up | req_down | req_left | req_right;
    assign walk_en = (state_q == MV_WALK) && !freeze;
    assign div_clr = (state_q != MV_WALK);

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (div_clr),
        .en     (walk_en),
        .tick_c (tick_c)
    );

    // Fixed-priority direction pick.
    always_comb begin
        req_dir = DIR_RIGHT;
        if (req_up) begin
            req_dir = DIR_UP;
        end else if (req_down) begin
            req_dir = DIR_DOWN;
        end else if (req_left) begin
            req_dir = DIR_LEFT;
        end
    end

    // Bounds check of the picked direction against the current position.
    always_comb begin
        req_legal = 1'b0;
        case (req_dir)
            DIR_UP:   req_legal = move_legal(CHK_W'(pos_r), MIN_R_W, MAX_R_W, 1'b1);
            DIR_DOWN: req_legal = move_legal(CHK_W'(pos_r), MIN_R_W, MAX_R_W, 1'b0);
            DIR_LEFT: req_legal = move_legal(CHK_W'(pos_c), MIN_C_W, MAX_C_W, 1'b1);
            default:  req_legal = move_legal(CHK_W'(pos_c), MIN_C_W, MAX_C_W, 1'b0);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; freeze holds the current state.
    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            case (state_q)
                MV_IDLE: begin
                    if (req_any) begin
                        state_d = req_legal ? MV_WALK : MV_BUMP;
                    end
                end
                MV_WALK: begin
                    if (tick_c && (pix_cnt == PIX_LAST)) begin
                        state_d = MV_IDLE;
                    end
                end
                MV_BUMP: begin
                    if (!req_any) begin
                        state_d = MV_IDLE;
                    end
                end
                default: state_d = MV_IDLE;
            endcase
        end
    end

    // Next values of the position, counter and registered outputs.
    always_comb begin
        pos_r_d   = pos_r;
        pos_c_d   = pos_c;
        facing_d  = dir_e'(facing);
        pix_d     = pix_cnt;
        blocked_d = 1'b0;
        if (!freeze && (state_q == MV_IDLE) && req_any) begin
            facing_d  = req_dir;
            pix_d     = '0;
            blocked_d = !req_legal;
        end
        if (tick_c) begin
            pix_d = pix_cnt + SPRITE_LOG_LEN'(1);
            case (facing)
                DIR_UP:   pos_r_d = pos_r - POS_W'(1);
                DIR_DOWN: pos_r_d = pos_r + POS_W'(1);
                DIR_LEFT: pos_c_d = pos_c - POS_W'(1);
                default:  pos_c_d = pos_c + POS_W'(1);
            endcase
        end
        busy_d = (state_d == MV_WALK);
        if (state_d != MV_WALK) begin
            frame_d = FRM_STAND;
        end else if (pix_d < PIX_HALF) begin
            frame_d = FRM_WALK_A;
        end else begin
            frame_d = FRM_WALK_B;
        end
    end

    // Position, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_r   <= POS_W'(INIT_R);
            pos_c   <= POS_W'(INIT_C);
            facing  <= DIR_DOWN;
            frame   <= FRM_STAND;
            busy    <= 1'b0;
            blocked <= 1'b0;
            pix_cnt <= '0;
        end else begin
            pos_r   <= pos_r_d;
            pos_c   <= pos_c_d;
            facing  <= facing_d;
            frame   <= frame_d;
            busy    <= busy_d;
            blocked <= blocked_d;
            pix_cnt <= pix_d;
        end
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Bench for sprite_move_ctrl: two instances (default start, and start row 10
// near the top wall) checked every cycle against a tile-walk model, plus
// hand-computed checkpoints from directed scenarios and random traffic.
module tb_sprite_move_ctrl;

    localparam int LEN = 32;
    localparam int DIV = 4;

    localparam int M_IDLE = 0;
    localparam int M_WALK = 1;
    localparam int M_BUMP = 2;

    typedef struct {
        int mode;
        int r;
        int c;
        int facing;
        int frame;
        int busy;
        int blocked;
        int elapsed;
        int sr;
        int sc;
    } mdl_t;

    logic       clk;
    logic       rst;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       frz_a;
    logic       frz_b;
    logic [9:0] pr_a, pc_a, pr_b, pc_b;
    logic [1:0] fc_a, fm_a, fc_b, fm_b;
    logic       bsy_a, blk_a, bsy_b, blk_b;

    mdl_t ma;
    mdl_t mb;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 0;

    sprite_move_ctrl #(.STEP_DIV(DIV)) u_a (
        .clk(clk), .rst(rst),
        .req_up(req_a[0]), .req_down(req_a[1]), .req_left(req_a[2]), .req_right(req_a[3]),
        .freeze(frz_a),
        .pos_r(pr_a), .pos_c(pc_a), .facing(fc_a), .frame(fm_a),
        .busy(bsy_a), .blocked(blk_a)
    );

    sprite_move_ctrl #(.STEP_DIV(DIV), .INIT_R(10)) u_b (
        .clk(clk), .rst(rst),
        .req_up(req_b[0]), .req_down(req_b[1]), .req_left(req_b[2]), .req_right(req_b[3]),
        .freeze(frz_b),
        .pos_r(pr_b), .pos_c(pc_b), .facing(fc_b), .frame(fm_b),
        .busy(bsy_b), .blocked(blk_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mdl_t mreset(input int r0, input int c0);
        mdl_t m;
        m.mode = M_IDLE; m.r = r0; m.c = c0; m.facing = 0; m.frame = 0;
        m.busy = 0; m.blocked = 0; m.elapsed = 0; m.sr = r0; m.sc = c0;
        return m;
    endfunction

    // One clock of behaviour: position is start + (elapsed walk clocks / DIV)
    // pixels in the facing direction; the tile ends after LEN*DIV clocks.
    function automatic mdl_t mstep(input mdl_t m, input logic [3:0] req, input logic frz,
                                   input int lo_r, input int hi_r, input int lo_c, input int hi_c);
        mdl_t n;
        int   d;
        bit   ok;
        int   mv;
        n = m;
        n.blocked = 0;
        if (frz) return n;
        if (m.mode == M_IDLE && req != 4'd0) begin
            if (req[0]) d = 1;
            else if (req[1]) d = 0;
            else if (req[2]) d = 2;
            else d = 3;
            case (d)
                1:       ok = (m.r >= lo_r + LEN);
                0:       ok = (m.r + LEN <= hi_r);
                2:       ok = (m.c >= lo_c + LEN);
                default: ok = (m.c + LEN <= hi_c);
            endcase
            n.facing = d;
            if (ok) begin
                n.mode = M_WALK; n.elapsed = 0; n.sr = m.r; n.sc = m.c;
            end else begin
                n.mode = M_BUMP; n.blocked = 1;
            end
        end else if (m.mode == M_WALK) begin
            n.elapsed = m.elapsed + 1;
            mv = n.elapsed / DIV;
            n.r = m.sr + ((m.facing == 1) ? -mv : (m.facing == 0) ? mv : 0);
            n.c = m.sc + ((m.facing == 2) ? -mv : (m.facing == 3) ? mv : 0);
            if (n.elapsed == LEN * DIV) n.mode = M_IDLE;
        end else if (m.mode == M_BUMP && req == 4'd0) begin
            n.mode = M_IDLE;
        end
        n.busy  = (n.mode == M_WALK) ? 1 : 0;
        n.frame = (n.mode != M_WALK) ? 0 : (((n.elapsed / DIV) < LEN / 2) ? 1 : 2);
        return n;
    endfunction

    // Model update, with the same asynchronous reset as the design.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                ma = mreset(300, 300);
                mb = mreset(10, 300);
            end else begin
                ma = mstep(ma, req_a, frz_a, 0, 448, 0, 608);
                mb = mstep(mb, req_b, frz_b, 0, 448, 0, 608);
            end
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t m,
                            input logic [9:0] r, input logic [9:0] c,
                            input logic [1:0] f, input logic [1:0] fr,
                            input logic b, input logic bl);
        cmp({tag, ".pos_r"},   int'(r),  m.r);
        cmp({tag, ".pos_c"},   int'(c),  m.c);
        cmp({tag, ".facing"},  int'(f),  m.facing);
        cmp({tag, ".frame"},   int'(fr), m.frame);
        cmp({tag, ".busy"},    int'(b),  m.busy);
        cmp({tag, ".blocked"}, int'(bl), m.blocked);
    endtask

    // Per-cycle model comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                cmp_inst("a", ma, pr_a, pc_a, fc_a, fm_a, bsy_a, blk_a);
                cmp_inst("b", mb, pr_b, pc_b, fc_b, fm_b, bsy_b, blk_b);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int blk_cnt;
        int moved;
        int low_cnt;

        rst = 1'b0;
        req_a = 4'd0; req_b = 4'd0;
        frz_a = 1'b0; frz_b = 1'b0;
        cyc(3);
        rst = 1'b1;
        chk_on = 1;

        // Reset values.
        cmp("rst.a.pos_r", int'(pr_a), 300);
        cmp("rst.a.pos_c", int'(pc_a), 300);
        cmp("rst.b.pos_r", int'(pr_b), 10);
        cmp("rst.a.busy",  int'(bsy_a), 0);

        // Single-cycle up pulse: full tile walk 300 -> 268.
        req_a = 4'b0001;
        cyc(1);
        req_a = 4'd0;
        cmp("up.busy_n1",   int'(bsy_a), 1);
        cmp("up.facing_n1", int'(fc_a), 1);
        cyc(3);
        cmp("up.pos_r_n3", int'(pr_a), 300);
        cyc(1);
        cmp("up.pos_r_n4", int'(pr_a), 299);
        cyc(59);
        cmp("up.pos_r_n63", int'(pr_a), 285);
        cmp("up.frame_n63", int'(fm_a), 1);
        cyc(1);
        cmp("up.pos_r_n64", int'(pr_a), 284);
        cmp("up.frame_n64", int'(fm_a), 2);
        cyc(63);
        cmp("up.pos_r_n127", int'(pr_a), 269);
        cmp("up.busy_n127",  int'(bsy_a), 1);
        cyc(1);
        cmp("up.pos_r_n128", int'(pr_a), 268);
        cmp("up.busy_n128",  int'(bsy_a), 0);
        cmp("up.frame_n128", int'(fm_a), 0);

        // Up + left together: up wins.
        req_a = 4'b0101;
        cyc(1);
        req_a = 4'd0;
        cmp("upleft.facing", int'(fc_a), 1);
        cyc(128);
        cmp("upleft.pos_r", int'(pr_a), 236);
        cmp("upleft.pos_c", int'(pc_a), 300);

        // Top wall on instance b: held up bumps once, then down walks.
        req_b = 4'b0001;
        blk_cnt = 0;
        moved = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (blk_b) blk_cnt++;
            if (pr_b != 10'd10 || bsy_b) moved++;
        end
        cmp("bump.blocked_cycles", blk_cnt, 1);
        cmp("bump.moved_cycles",   moved, 0);
        cmp("bump.facing",         int'(fc_b), 1);
        req_b = 4'd0;
        cyc(2);
        req_b = 4'b0010;
        cyc(1);
        req_b = 4'd0;
        cmp("bump.down_busy", int'(bsy_b), 1);
        cyc(128);
        cmp("bump.down_pos_r", int'(pr_b), 42);

        // Right walk with a 10-cycle freeze from clock 20.
        req_a = 4'b1000;
        cyc(1);
        req_a = 4'd0;
        cyc(19);
        frz_a = 1'b1;
        cyc(10);
        frz_a = 1'b0;
        cmp("frz.pos_c_held", int'(pc_a), 304);
        cyc(108);
        cmp("frz.pos_c_n137", int'(pc_a), 331);
        cmp("frz.busy_n137",  int'(bsy_a), 1);
        cyc(1);
        cmp("frz.pos_c_n138", int'(pc_a), 332);
        cmp("frz.busy_n138",  int'(bsy_a), 0);

        // Held right: two back-to-back tiles with one idle cycle between.
        req_a = 4'b1000;
        cyc(1);
        low_cnt = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (!bsy_a) low_cnt++;
            if (i == 128) cmp("hold.pos_c_first", int'(pc_a), 364);
            if (i == 129) cmp("hold.busy_restart", int'(bsy_a), 1);
        end
        req_a = 4'd0;
        cmp("hold.idle_gap", low_cnt, 1);
        cyc(1);
        cmp("hold.pos_c_second", int'(pc_a), 396);
        cyc(2);
        cmp("hold.no_third", int'(bsy_a), 0);

        // Reset mid-walk aborts immediately.
        req_a = 4'b0010;
        cyc(1);
        req_a = 4'd0;
        cyc(40);
        #2 rst = 1'b0;
        #1;
        cmp("midrst.pos_r",   int'(pr_a), 300);
        cmp("midrst.pos_c",   int'(pc_a), 300);
        cmp("midrst.facing",  int'(fc_a), 0);
        cmp("midrst.frame",   int'(fm_a), 0);
        cmp("midrst.busy",    int'(bsy_a), 0);
        cmp("midrst.blocked", int'(blk_a), 0);
        cmp("midrst.b_pos_r", int'(pr_b), 10);
        @(negedge clk);
        rst = 1'b1;
        cyc(5);
        cmp("midrst.no_resume", int'(pr_a), 300);

        // Random requests and freezes on both instances.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) req_b = 4'($urandom_range(0, 15));
            frz_a = ($urandom_range(0, 11) == 0);
            frz_b = ($urandom_range(0, 11) == 0);
        end
        req_a = 4'd0; req_b = 4'd0;
        frz_a = 1'b0; frz_b = 1'b0;
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_move_ctrl.md
# sprite_move_ctrl

Tile-step movement controller for the player sprite. It arbitrates the four debounced direction buttons and walks the sprite exactly one tile (SPRITE_LEN pixels) per accepted request, one pixel per STEP_DIV clocks. It clamps motion to a play-field rectangle and drives the sprite ROM bank select (facing + walk frame). It sits between the debounce stage and the pixel/ROM-mux logic, and replaces ad-hoc move_stat/move_cnt logic in the top level.

## Interface
- SPRITE_LEN, 32, tile size in screen pixels; must be a power of 2
- STEP_DIV, 32, clocks per 1-pixel step; ≥2
- INIT_R, 300, reset row of sprite top-left
- INIT_C, 300, reset column of sprite top-left
- MIN_R / MAX_R, 0 / 448, allowed range of pos_r, inclusive
- MIN_C / MAX_C, 0 / 608, allowed range of pos_c, inclusive

Ports:
- clk  in  1  block clock (the clk_13 domain)
- rst  in  1  asynchronous, active-low reset
- req_up, req_down, req_left, req_right  in  1 each  debounced level requests
- freeze  in  1  pause: all counters and state hold while high
- pos_r  out  10  sprite top-left row
- pos_c  out  10  sprite top-left column
- facing  out  2  DOWN=0, UP=1, LEFT=2, RIGHT=3
- frame  out  2  STAND=0, WALK_A=1, WALK_B=2
- busy  out  1  high while in WALK
- blocked  out  1  single-cycle pulse on a rejected request

## Operation
- States: IDLE, WALK, BUMP.
- Priority among simultaneous requests: up > down > left > right. Requests are sampled only in IDLE with freeze low. Requests that arrive in WALK or BUMP are ignored (no queueing).
- Legality is checked on 11-bit unsigned values:
  - up is legal iff pos_r ≥ MIN_R+SPRITE_LEN
  - down is legal iff pos_r+SPRITE_LEN ≤ MAX_R
  - left and right use the same rule on pos_c with MIN_C / MAX_C.
- IDLE, legal request: facing ← dir; div_cnt ← 0; pix_cnt ← 0; go to WALK.
- IDLE, illegal request: facing ← dir; blocked=1 for one cycle; go to BUMP.
- BUMP: hold until all four requests are low, then go to IDLE. A held illegal button therefore pulses blocked exactly once.
- WALK: div_cnt counts 0..STEP_DIV-1. When it equals STEP_DIV-1 (and freeze is low):
  - div_cnt wraps to 0;
  - pos moves ±1 in the facing direction;
  - pix_cnt increments.
- On the step where pix_cnt = SPRITE_LEN-1, the final pixel move and the transition to IDLE happen on the same edge.
- frame: STAND in IDLE and BUMP. In WALK it is WALK_A while pix_cnt < SPRITE_LEN/2, else WALK_B.
- freeze high: no state, counter or position change, and blocked is suppressed. Outputs hold their values.
- Counter widths: pix_cnt is log2(SPRITE_LEN) bits. div_cnt is clog2(STEP_DIV) bits and must never exceed STEP_DIV-1.

## Timing
- Reset values, asserted asynchronously and released synchronously:
  - pos_r=INIT_R, pos_c=INIT_C
  - facing=DOWN, frame=STAND
  - busy=0, blocked=0
  - state=IDLE, counters 0
- All outputs are registered; none depend combinationally on inputs.
- Accepted request seen at edge N: busy=1 and facing are valid after edge N.
- First pixel move occurs at edge N+STEP_DIV. Last move occurs at edge N+SPRITE_LEN·STEP_DIV, and busy=0 after that same edge.
- A continuously held legal request restarts a walk on the cycle after returning to IDLE. The minimum gap between walks is 1 IDLE cycle.
- A freeze of k cycles inside WALK delays completion by exactly k cycles.
- Reset mid-walk aborts immediately; there is no partial-tile completion.

## Structure
- Shared package sprite_pkg holds:
  - SPRITE_LEN and SPRITE_LOG_LEN;
  - direction codes DIR_DOWN/UP/LEFT/RIGHT;
  - frame codes FRM_STAND/WALK_A/WALK_B;
  - state encoding MV_IDLE/MV_WALK/MV_BUMP.
- The top level's pixel mux consumes facing/frame from the package codes.
- One sub-module: step_tick_gen. It holds the div_cnt counter with clear, enable (= WALK & ~freeze) and a tick output at STEP_DIV-1.
- Arbitration, legality, FSM and position registers stay in sprite_move_ctrl.

## Test plan
(Sim parameters unless noted: STEP_DIV=4, defaults otherwise.)
- Reset: drop rst mid-sim → immediately pos=(300,300), facing=0, frame=0, busy=0, blocked=0.
- req_up pulsed 1 cycle in IDLE → busy=1 and facing=1 next cycle.
  - pos_r=299 after 4 clocks; frame=1 until pos_r=284, then 2.
  - pos_r=268 and busy=0 at clock 128.
- req_up and req_left asserted together → facing=1, pos_c stays 300, pos_r decrements.
- INIT_R=MIN_R+10 (=10), req_up held 50 cycles → blocked high exactly 1 cycle, facing=1, pos_r=10 throughout, busy=0. After release, req_down walks normally to pos_r=42.
- freeze high for 10 cycles starting at clock 20 of a right walk → pos_c holds during freeze. pos_c=332 at clock 138, not 128.
- req_right held continuously → pos_c reaches 332 then 364. Exactly one busy-low cycle between the two walks; no requests are lost or duplicated.
